instruction_prefetch_queue: RTL and testbench

//  Fetch-stage front end of the five-stage LEGv8 pipeline; feeds the IF/ID register.

---
 rtl/instruction_prefetch_queue.sv | 105 ++++++++++
 tb/tb_instruction_prefetch_queue.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/instruction_prefetch_queue.sv
// Fetch-stage front end: issues sequential 4-byte fetches, buffers {pc, instr} pairs in a FIFO,
// and flushes/discards in-flight responses on a branch redirect.
module instruction_prefetch_queue #(
  parameter int DEPTH = 4
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startpc,
  output logic        imem_req,
  output logic [63:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [63:0] id_pc,
  output logic [31:0] id_instr
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);

  logic [63:0]   fetch_pc;
  logic [63:0]   resp_pc;
  logic [63:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;

  logic [CW:0]   credit_sum;
  logic          issue;
  logic          resp_acc;
  logic          push;
  logic          pop;
  logic [63:0]   start_aligned;
  logic [63:0]   redirect_aligned;

  assign start_aligned    = {startpc[63:2], 2'b00};
  assign redirect_aligned = {redirect_pc[63:2], 2'b00};

  // Credits cover both buffered entries and fetches still in flight, so a push never overflows.
  assign credit_sum = {1'b0, count} + {1'b0, outstanding};
  assign imem_req   = resetl && !redirect_valid && (credit_sum < (CW+1)'(DEPTH));
  assign imem_addr  = resetl ? fetch_pc : start_aligned;
  assign issue      = imem_req && imem_ready;

  // rvalid with nothing outstanding is ignored rather than corrupting the counters.
  assign resp_acc = resetl && imem_rvalid && (outstanding != '0);
  assign push     = resp_acc && (drop == '0) && !redirect_valid;

  assign id_valid = resetl && (count != '0);
  assign pop      = id_valid && id_ready;
  assign id_pc    = pc_mem[rd_ptr];
  assign id_instr = instr_mem[rd_ptr];

  always_ff @(posedge CLK) begin
    if (!resetl) begin
      fetch_pc    <= start_aligned;
      resp_pc     <= start_aligned;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(issue) - CW'(resp_acc);
      if (redirect_valid) begin
        // Every fetch still in flight belongs to the abandoned path.
        fetch_pc <= redirect_aligned;
        resp_pc  <= redirect_aligned;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        count    <= '0;
        drop     <= outstanding - CW'(resp_acc) + CW'(issue);
      end else begin
        if (issue)
          fetch_pc <= fetch_pc + 64'd4;
        if (resp_acc) begin
          if (drop != '0)
            drop <= drop - CW'(1);
          else
            resp_pc <= resp_pc + 64'd4;
        end
        if (push)
          wr_ptr <= wr_ptr + PW'(1);
        if (pop)
          rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (push) begin
      pc_mem[wr_ptr]    <= resp_pc;
      instr_mem[wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_instruction_prefetch_queue.sv
// Randomized bench for instruction_prefetch_queue: a latency-modelled memory plus an
// epoch-tagged scoreboard predicting every request, buffered entry and popped instruction.
module tb_instruction_prefetch_queue;

  logic        CLK = 1'b0;
  logic        resetl = 1'b0;
  logic [63:0] startpc = 64'h100;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_valid;
  logic        id_ready = 1'b0;
  logic [63:0] id_pc;
  logic [31:0] id_instr;

  instruction_prefetch_queue #(.DEPTH(4)) dut (
    .CLK(CLK), .resetl(resetl), .startpc(startpc),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc), .id_instr(id_instr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [63:0] addr;
    int          due;
    int          ep;
  } mreq_t;

  mreq_t       memq[$];
  logic [63:0] expq[$];
  logic [63:0] exp_fetch;
  int          epoch = 0;
  int          cyc = 0;
  int          pops = 0;
  int          checks = 0;
  int          errors = 0;
  int          lat_lo = 1, lat_hi = 1, rdy_pct = 100, idr_pct = 100;

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'hA5C3_0F00;
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs after the falling edge, check settled outputs, advance the model.
  task automatic step(input bit rl, input bit redir, input logic [63:0] tgt);
    bit          rv;
    logic [63:0] raddr;
    int          rep;
    @(negedge CLK);
    rv = 1'b0;
    raddr = '0;
    rep = -1;
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rv = 1'b1;
      raddr = memq[0].addr;
      rep = memq[0].ep;
    end
    resetl = rl;
    imem_rvalid = rv;
    imem_rdata = rv ? word_of(raddr) : $urandom;
    redirect_valid = redir;
    redirect_pc = tgt;
    imem_ready = ($urandom_range(99) < rdy_pct);
    id_ready = ($urandom_range(99) < idr_pct);
    #1;
    if (!rl) begin
      chk("rst_req", imem_req, 0);
      chk("rst_id_valid", id_valid, 0);
      chk("rst_addr", imem_addr, startpc);
      if (rv) void'(memq.pop_front());
      expq.delete();
      exp_fetch = startpc;
      epoch++;
    end else begin
      chk("req", imem_req, (!redir && (expq.size() + memq.size() < 4)));
      chk("id_valid", id_valid, (expq.size() > 0));
      if (id_valid && expq.size() > 0) begin
        chk("id_pc", id_pc, expq[0]);
        chk("id_instr", id_instr, word_of(expq[0]));
      end
      if (imem_req) chk("imem_addr", imem_addr, exp_fetch);
      if (id_valid && id_ready && expq.size() > 0) begin
        void'(expq.pop_front());
        pops++;
      end
      if (rv) begin
        void'(memq.pop_front());
        if (!redir && rep == epoch) expq.push_back(raddr);
      end
      if (imem_req && imem_ready) begin
        memq.push_back('{addr: exp_fetch, due: cyc + $urandom_range(lat_hi, lat_lo), ep: epoch});
        exp_fetch = exp_fetch + 64'd4;
      end
      if (redir) begin
        expq.delete();
        epoch++;
        exp_fetch = {tgt[63:2], 2'b00};
      end
    end
    cyc++;
  endtask

  task automatic run(input int n, input int redir_pct);
    logic [63:0] t;
    for (int i = 0; i < n; i++) begin
      t = {$urandom, $urandom};
      if ($urandom_range(9) == 0) t = 64'hFFFF_FFFF_FFFF_FFF3;
      step(1'b1, ($urandom_range(99) < redir_pct), t);
    end
  endtask

  initial begin
    exp_fetch = startpc;
    // reset, then plain streaming from 0x100 with 1-cycle memory
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, '0);
    run(20, 0);
    // decode stall fills the FIFO and stops fetch, then drains in order
    idr_pct = 0;
    run(10, 0);
    idr_pct = 100;
    run(10, 0);
    // 3-cycle memory with fetches in flight, redirect to a misaligned target
    lat_lo = 3; lat_hi = 3;
    run(6, 0);
    step(1'b1, 1'b1, 64'h403);
    run(10, 0);
    // redirect coinciding with a response and a pop; then back-to-back redirects
    lat_lo = 1; lat_hi = 1;
    run(6, 0);
    step(1'b1, 1'b1, 64'h403);
    run(4, 0);
    step(1'b1, 1'b1, 64'h800);
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    run(8, 0);
    // randomized handshakes and latency 1-3
    lat_lo = 1; lat_hi = 3; rdy_pct = 60; idr_pct = 70;
    run(600, 3);
    // reset with a full FIFO and responses still in flight
    idr_pct = 0; rdy_pct = 100;
    run(8, 0);
    startpc = 64'h2000;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0);
    idr_pct = 70; rdy_pct = 60;
    run(300, 3);
    chk("progress", (pops >= 300), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
